// File: rtl/cpm5_axis_credit_pkg.sv
// ---------------------------------------------------------------------------
// cpm5_axis_credit_pkg
// Shared definitions for the CPM5 credit-to-ready/valid bridge:
//   - state_e     : credit issue FSM states (IDLE, ACTIVE)
//   - cnt_w()     : width of every level/credit counter for a given depth.
//                   One extra bit so the value DEPTH itself is representable.
//   - CQ_USER_W / RC_USER_W : tuser widths of the CPM5 ext CQ and RC ports
// ---------------------------------------------------------------------------
package cpm5_axis_credit_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    localparam int CQ_USER_W = 466;
    localparam int RC_USER_W = 337;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cpm5_axis_credit_fifo.sv
// ---------------------------------------------------------------------------
// cpm5_axis_credit_fifo
// Synchronous first-word-fall-through FIFO with a registered head.
// Storage is an inferred RAM array; the head register always mirrors the
// oldest entry, so dout/valid come straight from flops. A write into an
// empty FIFO (or into a FIFO whose last entry is leaving) bypasses the RAM
// and lands directly in the head register, giving one cycle push-to-valid.
//
// Ports
//   clk     : clock
//   resetn  : synchronous active-low reset
//   push    : write din (ignored when full)
//   din     : write data, WIDTH bits
//   pop     : remove head (ignored when empty)
//   dout    : head entry (zero after reset)
//   valid   : head entry present
//   count   : entries held, 0..DEPTH
// ---------------------------------------------------------------------------
module cpm5_axis_credit_fifo
    import cpm5_axis_credit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       valid,
    output logic [cnt_w(DEPTH)-1:0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_inc;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] head_reg;

    logic             do_push;
    logic             do_pop;
    logic             head_from_mem;
    logic             head_from_din;

    assign do_push    = push && (count_reg != CW'(DEPTH));
    assign do_pop     = pop && (count_reg != '0);
    assign rd_ptr_inc = rd_ptr_reg + AW'(1);

    // The entry behind the head already sits in RAM whenever more than one
    // entry is held, so a pop reloads the head from there.
    assign head_from_mem = do_pop && (count_reg > CW'(1));
    // Otherwise the new beat becomes the head if nothing older will remain.
    assign head_from_din = do_push &&
                           ((count_reg == '0) || (do_pop && (count_reg == CW'(1))));

    // Every accepted beat is also written to RAM so the pointers stay simple:
    // the head register is a copy of mem[rd_ptr_reg].
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_reg <= '0;
        end else if (head_from_mem) begin
            head_reg <= mem[rd_ptr_inc];
        end else if (head_from_din) begin
            head_reg <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    assign dout  = head_reg;
    assign valid = (count_reg != '0);
    assign count = count_reg;

endmodule

// File: rtl/cpm5_axis_credit_bridge.sv
// ---------------------------------------------------------------------------
// cpm5_axis_credit_bridge
// Bridges a credit-flow-controlled beat source (CPM5 ext CQ/RC style, one
// credit per beat, no ready) to an AXI-Stream ready/valid master.
// Beats land in an internal FIFO of DEPTH entries; each popped beat becomes
// an owed credit that is handed back to the producer as a one-cycle pulse.
//
// Credit accounting (all unsigned, never wrapping):
//   owed        : credits still to be returned to the producer
//   outstanding : credits granted but not yet consumed by a beat
//   count       : beats held in the FIFO
//   owed + outstanding + count == DEPTH while overflow_err is low.
//
// Parameters
//   DATA_W : tdata width
//   USER_W : tuser width (CQ_USER_W or RC_USER_W for the CPM5 ports)
//   KEEP_W : tkeep width, expected to be DATA_W/32
//   DEPTH  : FIFO entries and total credits, power of two in 2..64
//
// Ports
//   axi_aclk, axi_aresetn   : clock, synchronous active-low reset
//   credit_en               : level, allows credits to be issued
//   s_tdata/tuser/tlast/tkeep/tvalid : producer beat, consumes a credit
//   s_credit                : one-cycle pulse per returned credit
//   m_tdata/tuser/tlast/tkeep/tvalid, m_tready : AXI-Stream master
//   fifo_level              : beats held
//   credit_outstanding      : credits granted and not yet used
//   overflow_err            : sticky, beat arrived with no credit granted
// ---------------------------------------------------------------------------
module cpm5_axis_credit_bridge
    import cpm5_axis_credit_pkg::*;
#(
    parameter int DATA_W = 1024,
    parameter int USER_W = CQ_USER_W,
    parameter int KEEP_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                      axi_aclk,
    input  logic                      axi_aresetn,
    input  logic                      credit_en,

    input  logic [DATA_W-1:0]         s_tdata,
    input  logic [USER_W-1:0]         s_tuser,
    input  logic                      s_tlast,
    input  logic [KEEP_W-1:0]         s_tkeep,
    input  logic                      s_tvalid,
    output logic                      s_credit,

    output logic [DATA_W-1:0]         m_tdata,
    output logic [USER_W-1:0]         m_tuser,
    output logic                      m_tlast,
    output logic [KEEP_W-1:0]         m_tkeep,
    output logic                      m_tvalid,
    input  logic                      m_tready,

    output logic [cnt_w(DEPTH)-1:0]   fifo_level,
    output logic [cnt_w(DEPTH)-1:0]   credit_outstanding,
    output logic                      overflow_err
);

    localparam int CW     = cnt_w(DEPTH);
    localparam int FIFO_W = DATA_W + USER_W + 1 + KEEP_W;

    // Bit positions inside a stored FIFO word {tdata, tuser, tlast, tkeep}.
    localparam int LAST_POS = KEEP_W;
    localparam int USER_LSB = KEEP_W + 1;
    localparam int DATA_LSB = KEEP_W + 1 + USER_W;

    state_e           state_reg;
    state_e           state_next;

    logic [CW-1:0]    owed_reg;
    logic [CW-1:0]    owed_next;
    logic [CW-1:0]    outstanding_reg;
    logic [CW-1:0]    outstanding_next;
    logic             s_credit_reg;
    logic             s_credit_next;
    logic             overflow_reg;
    logic             overflow_next;

    logic             issue;
    logic             push_ok;
    logic             beat_dropped;
    logic             pop;

    logic [FIFO_W-1:0] fifo_din;
    logic [FIFO_W-1:0] fifo_dout;
    logic              fifo_valid;
    logic [CW-1:0]     fifo_count;

    // -----------------------------------------------------------------------
    // Beat acceptance. A beat is only legal against a granted credit; the
    // FIFO can only be full when outstanding is zero, so the drop path also
    // covers the full case and no write is attempted then.
    // -----------------------------------------------------------------------
    assign push_ok      = s_tvalid && (outstanding_reg != '0);
    assign beat_dropped = s_tvalid && (outstanding_reg == '0);
    assign pop          = fifo_valid && m_tready;

    assign fifo_din = {s_tdata, s_tuser, s_tlast, s_tkeep};

    cpm5_axis_credit_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (axi_aclk),
        .resetn (axi_aresetn),
        .push   (push_ok),
        .din    (fifo_din),
        .pop    (pop),
        .dout   (fifo_dout),
        .valid  (fifo_valid),
        .count  (fifo_count)
    );

    // -----------------------------------------------------------------------
    // Credit FSM and counters. The FSM only gates credit issue; pushes, pops
    // and the owed accumulation keep running in IDLE so a credit_en drop
    // mid-stream loses nothing and issue resumes from the held owed count.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        issue            = 1'b0;
        owed_next        = owed_reg;
        outstanding_next = outstanding_reg;
        s_credit_next    = 1'b0;
        overflow_next    = overflow_reg;

        case (state_reg)
            IDLE: begin
                if (credit_en) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                issue = (owed_reg != '0);
                if (!credit_en) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // The pulse is registered, so it appears the cycle after the
        // decision; the counters move on the same edge as the pulse.
        s_credit_next    = issue;
        owed_next        = owed_reg + CW'(pop) - CW'(issue);
        outstanding_next = outstanding_reg + CW'(issue) - CW'(push_ok);

        if (beat_dropped) begin
            overflow_next = 1'b1;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            state_reg       <= IDLE;
            owed_reg        <= CW'(DEPTH);
            outstanding_reg <= '0;
            s_credit_reg    <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            owed_reg        <= owed_next;
            outstanding_reg <= outstanding_next;
            s_credit_reg    <= s_credit_next;
            overflow_reg    <= overflow_next;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign s_credit           = s_credit_reg;
    assign overflow_err       = overflow_reg;
    assign credit_outstanding = outstanding_reg;
    assign fifo_level         = fifo_count;

    assign m_tvalid = fifo_valid;
    assign m_tkeep  = fifo_dout[KEEP_W-1:0];
    assign m_tlast  = fifo_dout[LAST_POS];
    assign m_tuser  = fifo_dout[USER_LSB +: USER_W];
    assign m_tdata  = fifo_dout[DATA_LSB +: DATA_W];

endmodule

// File: tb/tb_cpm5_axis_credit_bridge.sv
// ---------------------------------------------------------------------------
// tb_cpm5_axis_credit_bridge
// Directed bench for cpm5_axis_credit_bridge at DATA_W=1024, USER_W=466,
// KEEP_W=32, DEPTH=16. Inputs change and outputs are sampled 1 time unit
// after each rising edge ("sample k" = state after edge k of a phase).
// ---------------------------------------------------------------------------
module tb_cpm5_axis_credit_bridge;

    localparam int DATA_W = 1024;
    localparam int USER_W = 466;
    localparam int KEEP_W = 32;
    localparam int DEPTH  = 16;
    localparam int CW     = 5;

    logic              clk;
    logic              axi_aresetn;
    logic              credit_en;
    logic [DATA_W-1:0] s_tdata;
    logic [USER_W-1:0] s_tuser;
    logic              s_tlast;
    logic [KEEP_W-1:0] s_tkeep;
    logic              s_tvalid;
    logic              s_credit;
    logic [DATA_W-1:0] m_tdata;
    logic [USER_W-1:0] m_tuser;
    logic              m_tlast;
    logic [KEEP_W-1:0] m_tkeep;
    logic              m_tvalid;
    logic              m_tready;
    logic [CW-1:0]     fifo_level;
    logic [CW-1:0]     credit_outstanding;
    logic              overflow_err;

    int errors = 0;
    int checks = 0;

    cpm5_axis_credit_bridge #(
        .DATA_W (DATA_W),
        .USER_W (USER_W),
        .KEEP_W (KEEP_W),
        .DEPTH  (DEPTH)
    ) dut (
        .axi_aclk           (clk),
        .axi_aresetn        (axi_aresetn),
        .credit_en          (credit_en),
        .s_tdata            (s_tdata),
        .s_tuser            (s_tuser),
        .s_tlast            (s_tlast),
        .s_tkeep            (s_tkeep),
        .s_tvalid           (s_tvalid),
        .s_credit           (s_credit),
        .m_tdata            (m_tdata),
        .m_tuser            (m_tuser),
        .m_tlast            (m_tlast),
        .m_tkeep            (m_tkeep),
        .m_tvalid           (m_tvalid),
        .m_tready           (m_tready),
        .fifo_level         (fifo_level),
        .credit_outstanding (credit_outstanding),
        .overflow_err       (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- beat patterns ----------------
    function automatic logic [DATA_W-1:0] beat_data(input int i);
        logic [DATA_W-1:0] d;
        for (int w = 0; w < DATA_W / 32; w++) begin
            d[w*32 +: 32] = (32'(i) * 32'h0100_0193) ^ (32'(w) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
        end
        return d;
    endfunction

    function automatic logic [USER_W-1:0] beat_user(input int i);
        logic [USER_W-1:0] u;
        for (int b = 0; b < USER_W; b++) begin
            u[b] = (((b * 7) + (i * 3)) % 5) == 0;
        end
        return u;
    endfunction

    function automatic logic [KEEP_W-1:0] beat_keep(input int i);
        return 32'hFFFF_FFFF >> (i % 32);
    endfunction

    function automatic logic beat_last(input int i);
        return (i % 4) == 3;
    endfunction

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_beat(input int i);
        s_tvalid = 1'b1;
        s_tdata  = beat_data(i);
        s_tuser  = beat_user(i);
        s_tlast  = beat_last(i);
        s_tkeep  = beat_keep(i);
    endtask

    task automatic idle_beat();
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tuser  = '0;
        s_tlast  = 1'b0;
        s_tkeep  = '0;
    endtask

    task automatic check_head(input string tag, input int i);
        logic [DATA_W-1:0] d;
        d = beat_data(i);
        check({tag, "_tvalid"},  512'(m_tvalid), 512'(1'b1));
        check({tag, "_tdata_lo"}, m_tdata[511:0], d[511:0]);
        check({tag, "_tdata_hi"}, m_tdata[1023:512], d[1023:512]);
        check({tag, "_tuser"},   512'(m_tuser), 512'(beat_user(i)));
        check({tag, "_tkeep"},   512'(m_tkeep), 512'(beat_keep(i)));
        check({tag, "_tlast"},   512'(m_tlast), 512'(beat_last(i)));
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_s_credit"},    512'(s_credit), 512'(0));
        check({tag, "_m_tvalid"},    512'(m_tvalid), 512'(0));
        check({tag, "_m_tdata_lo"},  m_tdata[511:0], 512'(0));
        check({tag, "_m_tdata_hi"},  m_tdata[1023:512], 512'(0));
        check({tag, "_m_tuser"},     512'(m_tuser), 512'(0));
        check({tag, "_m_tlast"},     512'(m_tlast), 512'(0));
        check({tag, "_m_tkeep"},     512'(m_tkeep), 512'(0));
        check({tag, "_fifo_level"},  512'(fifo_level), 512'(0));
        check({tag, "_outstanding"}, 512'(credit_outstanding), 512'(0));
        check({tag, "_overflow"},    512'(overflow_err), 512'(0));
    endtask

    // Caller has just released reset with credit_en high: expect one quiet
    // cycle, 16 back-to-back pulses, then silence with 16 credits granted.
    task automatic grant_check(input string tag);
        int extra;
        step();
        check({tag, "_first_gap"}, 512'(s_credit), 512'(0));
        for (int k = 0; k < DEPTH; k++) begin
            step();
            check({tag, "_pulse"}, 512'(s_credit), 512'(1));
        end
        extra = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (s_credit) extra++;
        end
        check({tag, "_no_extra"},    512'(extra), 512'(0));
        check({tag, "_outstanding"}, 512'(credit_outstanding), 512'(16));
        check({tag, "_level"},       512'(fifo_level), 512'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int seen;
        int more;
        logic exp_credit;

        axi_aresetn = 1'b0;
        credit_en   = 1'b0;
        m_tready    = 1'b0;
        idle_beat();

        // Reset state
        repeat (3) step();
        reset_check("rst0");
        $display("step: reset state checked");

        // Initial grant of 16 credits
        axi_aresetn = 1'b1;
        credit_en   = 1'b1;
        grant_check("grant0");
        $display("step: initial grant of 16 credits");

        // Fill with 16 beats, consumer stalled
        for (int i = 0; i < DEPTH; i++) begin
            drive_beat(i);
            step();
            if (i == 0) check_head("push_lat", 0);
            check("fill_no_credit", 512'(s_credit), 512'(0));
        end
        idle_beat();
        check("fill_level",       512'(fifo_level), 512'(16));
        check("fill_outstanding", 512'(credit_outstanding), 512'(0));
        check("fill_overflow",    512'(overflow_err), 512'(0));
        check_head("fill_head", 0);
        $display("step: 16 beats buffered with m_tready low");

        // 17th beat has no credit: dropped, error sticks
        drive_beat(16);
        step();
        idle_beat();
        check("ovf_flag",        512'(overflow_err), 512'(1));
        check("ovf_level",       512'(fifo_level), 512'(16));
        check("ovf_outstanding", 512'(credit_outstanding), 512'(0));
        check_head("ovf_head", 0);
        repeat (3) step();
        check("ovf_sticky",       512'(overflow_err), 512'(1));
        check("ovf_sticky_level", 512'(fifo_level), 512'(16));
        $display("step: overflow beat dropped, error sticky");

        // Drain: exactly beats 0..15 come out, dropped beat never appears
        m_tready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check_head("drain", i);
            step();
        end
        check("drain_empty", 512'(m_tvalid), 512'(0));
        check("drain_level", 512'(fifo_level), 512'(0));
        m_tready = 1'b0;
        $display("step: drained 16 beats in order");

        // Reset clears the error; grant repeats
        axi_aresetn = 1'b0;
        step();
        reset_check("rst1");
        axi_aresetn = 1'b1;
        grant_check("grant1");
        $display("step: reset cleared overflow, grant repeated");

        // Streaming: continuous push with m_tready high
        m_tready = 1'b1;
        for (int j = 0; j < 28; j++) begin
            if (j < 24) drive_beat(j + 32);
            else        idle_beat();
            step();
            if (j < 24) check_head("stream", j + 32);
            else        check("stream_tail_idle", 512'(m_tvalid), 512'(0));
            // Handshake in sample j-2 -> credit pulse in sample j
            exp_credit = (j >= 2) && (j <= 25);
            check("stream_credit", 512'(s_credit), 512'(exp_credit));
            check("stream_no_ovf", 512'(overflow_err), 512'(0));
        end
        check("stream_level",       512'(fifo_level), 512'(0));
        check("stream_outstanding", 512'(credit_outstanding), 512'(16));
        m_tready = 1'b0;
        $display("step: 24-beat stream at full rate");

        // credit_en drop after 8 pulses, pops while idle, then resume
        axi_aresetn = 1'b0;
        step();
        reset_check("rst2");
        axi_aresetn = 1'b1;
        seen = 0;
        for (int k = 0; k < 40 && seen < 7; k++) begin
            step();
            if (s_credit) seen++;
        end
        check("en_low_seen7", 512'(seen), 512'(7));
        // The pipeline still delivers the decision made while ACTIVE.
        credit_en = 1'b0;
        more = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (s_credit) more++;
        end
        check("en_low_last_pulse",  512'(more), 512'(1));
        check("en_low_outstanding", 512'(credit_outstanding), 512'(8));

        more = 0;
        for (int i = 0; i < 4; i++) begin
            drive_beat(100 + i);
            step();
            if (s_credit) more++;
        end
        idle_beat();
        check("en_low_level4",    512'(fifo_level), 512'(4));
        check_head("en_low_head", 100);
        m_tready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            if (s_credit) more++;
        end
        m_tready = 1'b0;
        check("en_low_no_pulses",     512'(more), 512'(0));
        check("en_low_drained",       512'(fifo_level), 512'(0));
        check("en_low_outstanding4",  512'(credit_outstanding), 512'(4));

        credit_en = 1'b1;
        step();
        check("resume_gap", 512'(s_credit), 512'(0));
        for (int k = 0; k < 12; k++) begin
            step();
            check("resume_pulse", 512'(s_credit), 512'(1));
        end
        more = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (s_credit) more++;
        end
        check("resume_no_extra",    512'(more), 512'(0));
        check("resume_outstanding", 512'(credit_outstanding), 512'(16));
        $display("step: credit_en low/high cycle, 12 credits resumed");

        // Reset mid-burst with 5 beats buffered
        for (int i = 0; i < 5; i++) begin
            drive_beat(200 + i);
            step();
        end
        idle_beat();
        check("mid_level5", 512'(fifo_level), 512'(5));
        axi_aresetn = 1'b0;
        step();
        reset_check("rst3");
        axi_aresetn = 1'b1;
        grant_check("grant3");
        $display("step: mid-burst reset, grant repeated");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
